// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store path.
// It accepts one request at a time and waits a programmable number of cycles.
// It then performs a single access with lane select, extension, and fault checks.
// The result is held until the consumer takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        accept, access;

  // The request is captured on acceptance and replayed at the access edge.
  logic        r_we, r_unsigned;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;

  // Access operands.
  // In IDLE they come straight from the request pins, which only matters when WAIT_CYCLES is 0.
  logic        a_we, a_unsigned, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [AW-1:0] a_idx;
  logic [3:0]  a_be;
  logic [31:0] a_wrep, rd_word, rd_shift, load_ext;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and access strobe.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (prevents latch inference).
    state_nxt = state;
    access    = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (wait_cnt == LAST_CNT) begin
        access    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand source select, fault check, store lane enables and load lane extraction.
  always_comb begin
    a_we       = (state == S_IDLE) ? req_we       : r_we;
    a_addr     = (state == S_IDLE) ? req_addr     : r_addr;
    a_wdata    = (state == S_IDLE) ? req_wdata    : r_wdata;
    a_size     = (state == S_IDLE) ? req_size     : r_size;
    a_unsigned = (state == S_IDLE) ? req_unsigned : r_unsigned;
    a_idx      = a_addr[AW+1:2];

    a_err = (a_size == 2'b11) ||
            (a_size == 2'b01 && a_addr[0]) ||
            (a_size == 2'b10 && a_addr[1:0] != 2'b00) ||
            (a_addr[31:2] >= DEPTH_W);

    a_be   = 4'b0000;
    a_wrep = a_wdata;
    case (a_size)
      2'b00: begin
        a_be   = 4'b0001 << a_addr[1:0];
        a_wrep = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        a_be   = a_addr[1] ? 4'b1100 : 4'b0011;
        a_wrep = {2{a_wdata[15:0]}};
      end
      default: a_be = 4'b1111;
    endcase

    rd_word  = mem[a_idx];
    rd_shift = rd_word >> {a_addr[1:0], 3'b000};
    case (a_size)
      2'b00:   load_ext = a_unsigned ? {24'd0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = a_unsigned ? {16'd0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  // Memory write on the access edge.
  // A reset held across the edge suppresses the write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; only control and response registers are cleared.
    if (access && a_we && !a_err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wrep[8*i +: 8];
      end
    end
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        r_we       <= req_we;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
      end
      if (state == S_WAIT) wait_cnt <= access ? 4'd0 : wait_cnt + 4'd1;
      if (access) begin
        rsp_rdata <= (a_err || a_we) ? 32'd0 : load_ext;
        rsp_err   <= a_err;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder.
// Instance 0 runs with WAIT_CYCLES=1 and instance 1 with WAIT_CYCLES=0.
// Checking combines directed table vectors, hand sequences for handshake and reset corners,
// and randomized traffic compared against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i * 4);
  endfunction

  // Reference model: memory is a flat byte array and the rules are applied directly.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic err);
    int n;
    logic [31:0] val, mask;
    n     = 1 << size;
    err   = (size == 2'b11) || ((addr % n) != 0) || (longint'(addr) >= 4 * DEPTH);
    rdata = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mbytes[addr + i] = wdata[8*i +: 8];
    end else begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val = val | (32'(mbytes[addr + i]) << (8 * i));
      if (n < 4 && !uns && val[8*n-1]) begin
        mask = (32'd1 << (8 * n)) - 32'd1;
        val  = val | ~mask;
      end
      rdata = val;
    end
  endtask

  // One request on instance s.
  // The task checks latency, holds the response for 'hold' cycles while checking stability,
  // and then checks the return to IDLE after the handshake.
  task automatic xact(input int s, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input int hold, output logic [31:0] rdata, output logic err);
    int lat;
    check("req_ready_idle", 32'(req_ready[s]), 32'd1);
    req_valid[s]    = 1'b1;
    req_we[s]       = we;
    req_addr[s]     = addr;
    req_wdata[s]    = wdata;
    req_size[s]     = size;
    req_unsigned[s] = uns;
    @(posedge clk); #1;
    req_valid[s]    = 1'b0;
    req_we[s]       = 1'($urandom);
    req_addr[s]     = $urandom;
    req_wdata[s]    = $urandom;
    req_size[s]     = 2'($urandom);
    req_unsigned[s] = 1'($urandom);
    lat = 1;
    while (!rsp_valid[s] && lat <= 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), (s == 0) ? 32'd2 : 32'd1);
    rdata = rsp_rdata[s];
    err   = rsp_err[s];
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid[s]), 32'd1);
      check("hold_rdata", rsp_rdata[s], rdata);
      check("hold_err", 32'(rsp_err[s]), 32'(err));
      check("hold_req_ready", 32'(req_ready[s]), 32'd0);
    end
    check("resp_req_ready", 32'(req_ready[s]), 32'd0);
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
    check("post_valid", 32'(rsp_valid[s]), 32'd0);
    check("post_ready", 32'(req_ready[s]), 32'd1);
    check("post_rdata", rsp_rdata[s], 32'd0);
    check("post_err", 32'(rsp_err[s]), 32'd0);
  endtask

  vec_t tbl [15];

  initial begin
    logic [31:0] rd, mrd, a;
    logic        er, mer, we, uns;
    logic [1:0]  sz;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = 32'd0; req_wdata[s] = 32'd0;
      req_size[s] = 2'b00; req_unsigned[s] = 1'b0; rsp_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_req_ready", 32'(req_ready[s]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[s], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill instance 0 with known contents, mirrored in the model.
    for (int i = 0; i < DEPTH; i++) begin
      model(1'b1, 32'(i * 4), init_word(i), 2'b10, 1'b0, mrd, mer);
      xact(0, 1'b1, 32'(i * 4), init_word(i), 2'b10, 1'b0, 0, rd, er);
      check("init_err", 32'(er), 32'(mer));
    end

    // Directed vectors for stores, lane loads, faults and range.
    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h23,  32'h00000080, 2'b00, 1'b0, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b0, 32'h23,  32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 32'h23,  32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h80DE0020, 1'b0};
    tbl[6]  = '{1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 32'h12,  32'h11111111, 2'b10, 1'b0, 32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 32'h10,  32'h0,        2'b11, 1'b0, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 32'h10,  32'h22222222, 2'b11, 1'b0, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[11] = '{1'b1, 32'h400, 32'hBADBAD00, 2'b10, 1'b0, 32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 32'h0,   32'h0,        2'b10, 1'b0, 32'hC0DE0000, 1'b0};
    tbl[13] = '{1'b0, 32'h22,  32'h0,        2'b01, 1'b0, 32'hFFFF80DE, 1'b0};
    tbl[14] = '{1'b0, 32'h22,  32'h0,        2'b01, 1'b1, 32'h000080DE, 1'b0};
    for (int i = 0; i < 15; i++) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, mrd, mer);
      xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, 0, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Hold the response with rsp_ready low for 5 cycles.
    xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd, er);
    check("hold_load_rdata", rd, 32'hDEADBEEF);
    check("hold_load_err", 32'(er), 32'd0);

    // Reset during WAIT drops the store.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40;
    req_wdata[0] = 32'h12345678; req_size[0] = 2'b10; req_unsigned[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("wait_req_ready", 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("async_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("async_rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("async_rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xact(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("rst_wait_no_write", rd, 32'hC0DE0040);

    // Randomized traffic against the model, including misaligned, illegal and out-of-range cases.
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      a   = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(4*DEPTH, 4*DEPTH + 64))
                                         : 32'($urandom_range(0, 4*DEPTH - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      rd = $urandom;
      model(we, a, rd, sz, uns, mrd, mer);
      xact(0, we, a, rd, sz, uns, 0, rd, er);
      check($sformatf("rand%0d_rdata@%h", n, a), rd, mrd);
      check($sformatf("rand%0d_err@%h", n, a), 32'(er), 32'(mer));
    end

    // Zero-wait instance: latency 1 plus a few lane cases.
    xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er);
    check("w0_store_err", 32'(er), 32'd0);
    xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("w0_load_word", rd, 32'hDEADBEEF);
    xact(1, 1'b1, 32'h11, 32'h0000007F, 2'b00, 1'b0, 0, rd, er);
    xact(1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check("w0_byte_merge", rd, 32'hDEAD7FEF);
    xact(1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, er);
    check("w0_byte_signed", rd, 32'hFFFFFFDE);
    xact(1, 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, er);
    check("w0_misaligned_err", 32'(er), 32'd1);
    check("w0_misaligned_rdata", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
